spm_dma: RTL and testbench
==========================

# spm_dma

Single-channel block-transfer engine that acts as the initiator on the scratch-pad-memory (SPM) access port. It copies a range of SPM words from a source address to a destination address, or fills a range with a constant. It sits beside the CPU as a second SPM master: a bus arbiter or mux in front of the SPM selects between this block and the CPU. The block only generates the strobe, read/write, address and data sequence the SPM expects, and consumes the SPM's one-cycle-latency read data.

## Interface
Parameters:
- ADDR_W, 12, SPM word-address width (matches `SpmAddrBus`)
- DATA_W, 32, word width (matches `WordData`)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  stop the transfer at the next clock edge
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source start word address
- dst_addr  in  ADDR_W  destination start word address
- len  in  ADDR_W  number of words to transfer
- fill_data  in  DATA_W  constant used in fill mode
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when a transfer completes normally
- aborted  out  1  one-cycle pulse when a transfer ends through abort
- checksum  out  DATA_W  present only with SPM_DMA_CHECKSUM_EN
- spm_addr  out  ADDR_W  SPM word address
- spm_as_  out  1  SPM address strobe, active low (`ENABLE_`)
- spm_rw  out  1  `READ` or `WRITE`
- spm_wr_data  out  DATA_W  SPM write data
- spm_rd_data  in  DATA_W  SPM read data; valid in the cycle after a read strobe

## Operation
- Values captured on an accepted start: mode, src_addr, dst_addr, len and fill_data are registered into internal src_q, dst_q, cnt_q and data_q. Inputs may change after that.
- start while busy: ignored.
- len = 0: the engine goes from IDLE to DONE with no SPM access. done pulses one cycle after start.
- FSM states: IDLE, RD, LAT, WR, FILL, DONE.
- IDLE:
  - spm_as_ = `DISABLE_`.
  - start with len≠0 and mode=0 → RD.
  - start with len≠0 and mode=1 → FILL.
- RD: spm_as_ = `ENABLE_`, spm_rw = `READ`, spm_addr = src_q. Next state is LAT.
- LAT: spm_as_ = `DISABLE_`. data_q ← spm_rd_data at the end of the cycle. Next state is WR.
- WR:
  - spm_as_ = `ENABLE_`, spm_rw = `WRITE`, spm_addr = dst_q, spm_wr_data = data_q.
  - src_q and dst_q increment; cnt_q decrements.
  - If cnt_q = 1, next state is DONE; otherwise RD.
- FILL:
  - spm_as_ = `ENABLE_`, spm_rw = `WRITE`, spm_addr = dst_q, spm_wr_data = data_q.
  - dst_q increments and cnt_q decrements every cycle.
  - If cnt_q = 1, next state is DONE.
- DONE: done = 1, spm_as_ = `DISABLE_`. Next state is IDLE.
- Address arithmetic is modulo 2^ADDR_W: address 0xFFF is followed by 0x000.
- Overlapping copy runs forward only. With dst > src and overlapping ranges, the copied data propagates; this is the defined behaviour.
- abort in any non-IDLE state:
  - The access in the current cycle still completes.
  - The next state is IDLE. aborted pulses in that next cycle and done does not pulse.
  - abort in IDLE does nothing.
- Outputs registered: spm_addr, spm_as_, spm_rw, spm_wr_data, busy, done and aborted are driven from registers or decoded from the state register. There is no combinational path from spm_rd_data to any output.

## Timing
- Reset values:
  - State is IDLE.
  - spm_as_ = `DISABLE_`, spm_rw = `READ`.
  - spm_addr = 0, spm_wr_data = 0.
  - busy = 0, done = 0, aborted = 0, checksum = 0.
- Edge numbering: start is sampled at edge 0.
- Copy of N words:
  - Accesses occupy cycles 1 to 3N, in the pattern RD, LAT, WR per word.
  - done is high in cycle 3N+1; busy is low from cycle 3N+2.
- Fill of N words:
  - Writes occupy cycles 1 to N; done is high in cycle N+1.
- A new start is accepted in the cycle after DONE, with no dead cycle beyond that.
- Reset mid-transfer: outputs go to their reset values immediately. Any partial write sequence is left as-is in the SPM.

## Configuration
SPM_DMA_CHECKSUM_EN:
- When defined:
  - The checksum port exists.
  - checksum is cleared on an accepted start.
  - checksum accumulates the sum, modulo 2^DATA_W, of every word written.
  - checksum holds its value after done or aborted until the next start.
- When undefined:
  - The port and its adder are absent.
  - All other behaviour is identical.

## Structure
- Shared package: the state encoding, the mode encoding (MODE_COPY, MODE_FILL), and the ADDR_W/DATA_W defaults tied to `SpmAddrBus`/`WordData`.
- `ENABLE_`/`DISABLE_`/`READ`/`WRITE` come from the existing shared headers.
- Sub-module spm_dma_ctr: loadable address/count register with increment or decrement and modulo wrap. It is instantiated for src_q, dst_q and cnt_q.

## Test plan
- Fill:
  - Stimulus: fill with dst=0x010, len=4, fill_data=0xA5A5_0000.
  - Required: SPM words 0x010–0x013 read back 0xA5A5_0000; done high in cycle 5; exactly 4 write strobes.
  - With SPM_DMA_CHECKSUM_EN: checksum = 0x9694_0000.
- Copy:
  - Stimulus: SPM preloaded with 0xFF−i at addresses i = 0–15; copy src=0x000, dst=0x100, len=16.
  - Required: 0x100–0x10F hold 0xFF–0xF0; done in cycle 49; every write follows its read by 2 cycles.
- Wrap-around:
  - Stimulus: fill dst=0xFFE, len=4, fill_data=0x1.
  - Required: addresses 0xFFE, 0xFFF, 0x000 and 0x001 are written; no other addresses are touched.
- Zero length:
  - Stimulus: start with len=0.
  - Required: spm_as_ never asserted; done high in cycle 1; busy high for that cycle only.
- Abort:
  - Stimulus: copy with len=8, abort asserted in cycle 7.
  - Required: exactly 2 words are written; aborted pulses in cycle 8; done never pulses; busy low from cycle 8.
- Busy and reset:
  - Stimulus 1: a second start during busy.
  - Required: it is ignored.
  - Stimulus 2: rst_n asserted mid-copy.
  - Required: spm_as_ is `DISABLE_` at once; after release, a new fill executes correctly.

Source files
------------

// File: rtl/spm_dma_pkg.sv
// Shared types and constants for the SPM block-transfer engine.
package spm_dma_pkg;

    typedef logic [11:0] SpmAddrBus;
    typedef logic [31:0] WordData;

    localparam int unsigned SPM_ADDR_W = $bits(SpmAddrBus);
    localparam int unsigned SPM_DATA_W = $bits(WordData);

    // SPM strobe and direction levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_FILL = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/spm_dma_ctr.sv
// Loadable address/count register that steps up or down with modulo-2^W wrap.
module spm_dma_ctr #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic         dec_i,
    output logic [W-1:0] val_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Load has priority over stepping; arithmetic wraps naturally at W bits.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (step_i) begin
            val_d = dec_i ? (val_q - W'(1)) : (val_q + W'(1));
        end
    end

    // Value register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/spm_dma.sv
// Single-channel SPM copy/fill engine acting as a second SPM master.
// Optional feature: SPM_DMA_CHECKSUM_EN adds a running sum of written words.
module spm_dma
    import spm_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = SPM_ADDR_W,
    parameter int unsigned DATA_W = SPM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
`ifdef SPM_DMA_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              aborted_q;
    logic              start_acc;
    logic              is_wr;

    assign start_acc = start && (state_q == ST_IDLE);
    assign is_wr     = (state_q == ST_WR) || (state_q == ST_FILL);

    spm_dma_ctr #(.W(ADDR_W)) u_src (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start_acc),
        .load_val_i (src_addr),
        .step_i     (state_q == ST_WR),
        .dec_i      (1'b0),
        .val_o      (src_q)
    );

    spm_dma_ctr #(.W(ADDR_W)) u_dst (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start_acc),
        .load_val_i (dst_addr),
        .step_i     (is_wr),
        .dec_i      (1'b0),
        .val_o      (dst_q)
    );

    spm_dma_ctr #(.W(ADDR_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start_acc),
        .load_val_i (len),
        .step_i     (is_wr),
        .dec_i      (1'b1),
        .val_o      (cnt_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_LAT;
            ST_LAT:  state_d = ST_WR;
            ST_WR:   state_d = (cnt_q == ADDR_W'(1)) ? ST_DONE : ST_RD;
            ST_FILL: state_d = (cnt_q == ADDR_W'(1)) ? ST_DONE : ST_FILL;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode from the state register and datapath registers only.
    always_comb begin
        spm_as_     = DISABLE_;
        spm_rw      = READ;
        spm_addr    = '0;
        spm_wr_data = '0;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        aborted     = aborted_q;
        case (state_q)
            ST_RD: begin
                spm_as_  = ENABLE_;
                spm_rw   = READ;
                spm_addr = src_q;
            end
            ST_WR, ST_FILL: begin
                spm_as_     = ENABLE_;
                spm_rw      = WRITE;
                spm_addr    = dst_q;
                spm_wr_data = data_q;
            end
            default: ;
        endcase
    end

    // Data holding register: fill constant on start, read word in the latency cycle.
    always_comb begin
        data_d = data_q;
        if (start_acc) begin
            data_d = fill_data;
        end else if (state_q == ST_LAT) begin
            data_d = spm_rd_data;
        end
    end

    // Data and abort-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            aborted_q <= abort && (state_q != ST_IDLE);
        end
    end

`ifdef SPM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_d;

    // Running sum of written words, cleared on each accepted start.
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (is_wr) begin
            checksum_d = checksum_q + data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_spm_dma.sv
// Self-checking bench for spm_dma: SPM model, write scoreboard and timing checks.
module tb_spm_dma;
    import spm_dma_pkg::*;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [11:0] len;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [11:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
`ifdef SPM_DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    spm_dma dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
`ifdef SPM_DMA_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_rd_data (spm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPM model with one-cycle read latency.
    logic [31:0] spm [4096];
    logic [31:0] ref_mem [4096];
    bit          pre_en;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 4096; i++) begin
                spm[i] <= (i < 16) ? (32'hFF - 32'(i)) : 32'h0;
            end
        end else if (spm_as_ == ENABLE_) begin
            if (spm_rw == READ) spm_rd_data <= spm[spm_addr];
            else                spm[spm_addr] <= spm_wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    wr_t wr_q[$];
    int  rd_q[$];
    int  t0, first_busy, last_busy, done_cyc, abt_cyc, n_done, n_abt, n_wr, n_exp;
    bit  mon_en, is_copy;

    always @(negedge clk) begin
        int  c;
        int  r;
        wr_t e;
        c = cyc - t0 + 1;
        if (mon_en) begin
            if (busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (aborted) begin
                n_abt++;
                abt_cyc = c;
            end
            if (spm_as_ == ENABLE_) begin
                if (spm_rw == READ) begin
                    rd_q.push_back(c);
                end else begin
                    n_wr++;
                    if (wr_q.size() == 0) begin
                        check("extra_write_count", 64'(n_wr), 64'(n_exp));
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", 64'(spm_addr), 64'(e.addr));
                        check("wr_data", 64'(spm_wr_data), 64'(e.data));
                    end
                    if (is_copy && rd_q.size() > 0) begin
                        r = rd_q.pop_front();
                        check("rd_to_wr_gap", 64'(c - r), 64'(2));
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic m, input logic [11:0] s, input logic [11:0] d,
                            input logic [11:0] l, input logic [31:0] fd, input int nexp,
                            input int abort_at, input int restart_at, input int rst_at);
        int          exp_done;
        int          exp_last;
        int          ncyc;
        logic [11:0] a;
        logic [11:0] sa;
        logic [31:0] v;
        logic [31:0] ck;
        wr_q.delete();
        rd_q.delete();
        ck = '0;
        for (int i = 0; i < nexp; i++) begin
            a  = d + 12'(i);
            sa = s + 12'(i);
            v  = (m == MODE_FILL) ? fd : ref_mem[sa];
            ref_mem[a] = v;
            wr_q.push_back('{addr: a, data: v});
            ck = ck + v;
        end
        exp_done = (l == 0) ? 1 : ((m == MODE_FILL) ? int'(l) + 1 : 3 * int'(l) + 1);
        ncyc     = exp_done + 3;
        exp_last = exp_done;
        if (abort_at > 0) begin exp_done = -1; exp_last = abort_at; end
        if (rst_at > 0)   begin exp_done = -1; exp_last = rst_at;   end
        first_busy = -1; last_busy = -1; done_cyc = -1; abt_cyc = -1;
        n_done = 0; n_abt = 0; n_wr = 0; n_exp = nexp; is_copy = (m == MODE_COPY);

        @(negedge clk); #2;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = fd;
        @(posedge clk); #1;
        t0 = cyc;
        mon_en = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk); #2;
            start = 1'b0;
            abort = (k == abort_at);
            if (k == restart_at) begin
                start = 1'b1; mode = ~m; src_addr = 12'h007; dst_addr = 12'h400;
                len = 12'd5; fill_data = 32'hDEAD;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_as_disable", 64'(spm_as_), 64'(DISABLE_));
                check("rst_busy_low", 64'(busy), 64'(0));
            end
            if (rst_at > 0 && k == rst_at + 2) rst_n = 1'b1;
        end
        mon_en = 1'b0;
        abort  = 1'b0;

        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("done_pulses", 64'(n_done), 64'((exp_done > 0) ? 1 : 0));
        check("aborted_cycle", 64'(abt_cyc), 64'((abort_at > 0) ? abort_at + 1 : -1));
        check("aborted_pulses", 64'(n_abt), 64'((abort_at > 0) ? 1 : 0));
        check("busy_first", 64'(first_busy), 64'(1));
        check("busy_last", 64'(last_busy), 64'(exp_last));
        check("write_count", 64'(n_wr), 64'(nexp));
        check("writes_pending", 64'(wr_q.size()), 64'(0));
`ifdef SPM_DMA_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'((rst_at > 0) ? 32'h0 : ck));
`endif
        for (int i = 0; i < nexp; i++) begin
            a = d + 12'(i);
            check("readback", 64'(spm[a]), 64'(ref_mem[a]));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        mon_en = 1'b0; t0 = 0; pre_en = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = (i < 16) ? (32'hFF - 32'(i)) : 32'h0;
        @(posedge clk); #1;
        pre_en = 1'b0;
        @(negedge clk);
        check("reset_as", 64'(spm_as_), 64'(DISABLE_));
        check("reset_rw", 64'(spm_rw), 64'(READ));
        check("reset_addr", 64'(spm_addr), 64'(0));
        check("reset_wdata", 64'(spm_wr_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_aborted", 64'(aborted), 64'(0));
`ifdef SPM_DMA_CHECKSUM_EN
        check("reset_checksum", 64'(checksum), 64'(0));
`endif
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Fill 4 words at 0x010.
        run_xfer(MODE_FILL, 12'h000, 12'h010, 12'd4, 32'hA5A5_0000, 4, 0, 0, 0);
`ifdef SPM_DMA_CHECKSUM_EN
        check("fill_checksum_const", 64'(checksum), 64'(32'h9694_0000));
`endif
        // Copy 16 preloaded words to 0x100.
        run_xfer(MODE_COPY, 12'h000, 12'h100, 12'd16, 32'h0, 16, 0, 0, 0);
        // Fill across the top of the address space.
        run_xfer(MODE_FILL, 12'h000, 12'hFFE, 12'd4, 32'h1, 4, 0, 0, 0);
        check("wrap_untouched_lo", 64'(spm[12'h002]), 64'(32'hFD));
        check("wrap_untouched_hi", 64'(spm[12'hFFD]), 64'(0));
        // Zero length.
        run_xfer(MODE_COPY, 12'h000, 12'h050, 12'd0, 32'h0, 0, 0, 0, 0);
        // Abort a copy in cycle 7.
        run_xfer(MODE_COPY, 12'h000, 12'h200, 12'd8, 32'h0, 2, 7, 0, 0);
        check("abort_third_untouched", 64'(spm[12'h202]), 64'(0));
        // Second start while busy is ignored.
        run_xfer(MODE_FILL, 12'h000, 12'h300, 12'd6, 32'h0BAD_F00D, 6, 0, 3, 0);
        check("restart_no_write", 64'(spm[12'h400]), 64'(0));
        // Reset in the middle of a copy, then a fresh fill.
        run_xfer(MODE_COPY, 12'h003, 12'h500, 12'd8, 32'h0, 1, 0, 0, 5);
        run_xfer(MODE_FILL, 12'h000, 12'h600, 12'd3, 32'h0000_1234, 3, 0, 0, 0);
        // Overlapping forward copy propagates data.
        run_xfer(MODE_COPY, 12'h100, 12'h101, 12'd4, 32'h0, 4, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
